// File: rtl/mem_access_stage_if.sv
// Signal bundle for the memory-access stage: execute-side entry, writeback-side result
// and the single-outstanding data-memory port.
interface mem_access_stage_if #(
   parameter int XLEN = 64,
   parameter int AW   = 64,
   parameter int RDW  = 5
);
   logic            in_valid;
   logic            in_ready;
   logic            in_regwr;
   logic            in_memrd;
   logic            in_memwr;
   logic [2:0]      in_memop;
   logic [RDW-1:0]  in_rd;
   logic [AW-1:0]   in_addr;
   logic [XLEN-1:0] in_wdata;
   logic [AW-1:0]   in_pc;
   logic            in_error;

   logic            out_valid;
   logic            out_ready;
   logic            out_regwr;
   logic [RDW-1:0]  out_rd;
   logic [XLEN-1:0] out_data;
   logic [AW-1:0]   out_pc;
   logic            out_error;

   logic              mem_req;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [XLEN-1:0]   mem_wdata;
   logic [XLEN/8-1:0] mem_wstrb;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [XLEN-1:0]   mem_rdata;

   // Environment side: execute stage, writeback stage and data memory.
   modport master (
      output in_valid, in_regwr, in_memrd, in_memwr, in_memop, in_rd, in_addr,
             in_wdata, in_pc, in_error, out_ready, mem_gnt, mem_rvalid, mem_rdata,
      input  in_ready, out_valid, out_regwr, out_rd, out_data, out_pc, out_error,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   // Stage side.
   modport slave (
      input  in_valid, in_regwr, in_memrd, in_memwr, in_memop, in_rd, in_addr,
             in_wdata, in_pc, in_error, out_ready, mem_gnt, mem_rvalid, mem_rdata,
      output in_ready, out_valid, out_regwr, out_rd, out_data, out_pc, out_error,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline memory-access stage: aligns stores, extracts/extends loads, flags misaligned
// accesses and holds one result for writeback with a single outstanding memory transaction.
module mem_access_stage #(
   parameter int XLEN = 64,
   parameter int AW   = 64,
   parameter int RDW  = 5
) (
   input  logic              clk,
   input  logic              rst,
   mem_access_stage_if.slave bus
);
   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
   state_t state_q, state_d;

   logic            ready_c, accept, done_now;
   logic            is_mem, misaligned, bad_size, mem_err, direct;
   logic [2:0]      align_mask;
   logic [NB-1:0]   size_strb;
   logic [OFFW-1:0] in_off;

   logic            we_q, load_q, regwr_q;
   logic [2:0]      memop_q;
   logic [AW-1:0]   addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [NB-1:0]   wstrb_q;

   logic            out_regwr_q, out_error_q;
   logic [RDW-1:0]  out_rd_q;
   logic [XLEN-1:0] out_data_q;
   logic [AW-1:0]   out_pc_q;

   logic [XLEN-1:0] rshift, load_data;

   assign is_mem     = bus.in_memrd | bus.in_memwr;
   assign in_off     = bus.in_addr[OFFW-1:0];
   assign misaligned = |(bus.in_addr[2:0] & align_mask);
   // Doubleword and WU loads do not exist on a 32-bit datapath.
   assign bad_size   = (XLEN == 32) &&
                       ((bus.in_memop[1:0] == 2'd3) || (bus.in_memrd && bus.in_memop == 3'b110));
   assign mem_err    = is_mem && (misaligned || bad_size);
   assign direct     = !is_mem || bus.in_error || mem_err;
   assign done_now   = (state_q == WAIT) && bus.mem_rvalid;

   // NOTE: every signal written in an always_comb gets a default first, so no path
   // through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      align_mask = 3'b000;
      size_strb  = '0;
      case (bus.in_memop[1:0])
         2'd0:    align_mask = 3'b000;
         2'd1:    align_mask = 3'b001;
         2'd2:    align_mask = 3'b011;
         default: align_mask = 3'b111;
      endcase
      for (int i = 0; i < NB; i++) size_strb[i] = (i < (1 << bus.in_memop[1:0]));
   end

   always_comb begin
      rshift    = bus.mem_rdata >> {addr_q[OFFW-1:0], 3'b000};
      load_data = rshift;
      case (memop_q)
         3'b000:  load_data = XLEN'($signed(rshift[7:0]));
         3'b001:  load_data = XLEN'($signed(rshift[15:0]));
         3'b010:  load_data = XLEN'($signed(rshift[31:0]));
         3'b100:  load_data = XLEN'(rshift[7:0]);
         3'b101:  load_data = XLEN'(rshift[15:0]);
         3'b110:  load_data = XLEN'(rshift[31:0]);
         default: load_data = rshift;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ready_c = 1'b0;
      case (state_q)
         IDLE:    ready_c = 1'b1;
         HOLD:    ready_c = bus.out_ready;
         default: ready_c = 1'b0;
      endcase
      accept = ready_c && rst && bus.in_valid;
      case (state_q)
         IDLE, HOLD: begin
            if (accept)                                state_d = direct ? HOLD : REQ;
            else if (state_q == HOLD && bus.out_ready) state_d = IDLE;
         end
         REQ:     if (bus.mem_gnt)    state_d = WAIT;
         WAIT:    if (bus.mem_rvalid) state_d = HOLD;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         we_q        <= 1'b0;
         load_q      <= 1'b0;
         regwr_q     <= 1'b0;
         memop_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         out_regwr_q <= 1'b0;
         out_error_q <= 1'b0;
         out_rd_q    <= '0;
         out_data_q  <= '0;
         out_pc_q    <= '0;
      end else begin
         if (accept) begin
            out_rd_q <= bus.in_rd;
            out_pc_q <= bus.in_pc;
            if (direct) begin
               out_data_q  <= bus.in_addr[XLEN-1:0];
               out_error_q <= bus.in_error | mem_err;
               out_regwr_q <= bus.in_regwr & ~(bus.in_error | mem_err);
            end else begin
               we_q        <= bus.in_memwr;
               load_q      <= ~bus.in_memwr;
               regwr_q     <= bus.in_regwr;
               memop_q     <= bus.in_memop;
               addr_q      <= bus.in_addr;
               wdata_q     <= bus.in_wdata << {in_off, 3'b000};
               wstrb_q     <= bus.in_memwr ? (size_strb << in_off) : '0;
               out_error_q <= 1'b0;
               out_regwr_q <= 1'b0;
            end
         end
         if (done_now) begin
            out_data_q  <= load_q ? load_data : addr_q[XLEN-1:0];
            out_regwr_q <= load_q & regwr_q;
         end
      end
   end

   assign bus.in_ready  = ready_c & rst;
   assign bus.out_valid = (state_q == HOLD);
   assign bus.out_regwr = out_regwr_q;
   assign bus.out_rd    = out_rd_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_pc    = out_pc_q;
   assign bus.out_error = out_error_q;
   assign bus.mem_req   = (state_q == REQ);
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_wstrb = wstrb_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: a transaction-level model predicts every output
// each cycle; a directed prologue pins the model with hand-computed values.
module tb_mem_access_stage;
   localparam int XLEN = 64;
   localparam int AW   = 64;
   localparam int RDW  = 5;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   n_done = 0;

   always #5 clk = ~clk;

   mem_access_stage_if #(.XLEN(XLEN), .AW(AW), .RDW(RDW)) bus ();

   mem_access_stage #(.XLEN(XLEN), .AW(AW), .RDW(RDW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic           regwr;
      logic [RDW-1:0] rd;
      logic [63:0]    data;
      logic [63:0]    pc;
      logic           err;
   } wb_t;

   wb_t         hold, p_res;
   bit          hold_v = 0;
   int          phase  = 0;    // 0: nothing in flight, 1: requesting, 2: awaiting response
   bit          p_store;
   logic [63:0] p_addr, p_wdata;
   logic [7:0]  p_strb;
   logic [2:0]  p_op;

   function automatic logic [63:0] load_val(input logic [63:0] rdata, input logic [63:0] addr,
                                            input logic [2:0] op);
      int          n    = 1 << op[1:0];
      logic [63:0] v    = rdata >> (8 * addr[2:0]);
      logic [63:0] mask = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
      v = v & mask;
      if (!op[2] && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   initial begin : monitor
      bit exp_rdy, acc, mem, mis;
      int n, off;
      forever begin
         @(negedge clk);
         exp_rdy = rst && (phase == 0) && (!hold_v || bus.out_ready);
         check("in_ready", bus.in_ready, exp_rdy);
         check("out_valid", bus.out_valid, hold_v);
         check("mem_req", bus.mem_req, phase == 1);
         if (hold_v) begin
            check("out_regwr", bus.out_regwr, hold.regwr);
            check("out_rd", bus.out_rd, hold.rd);
            check("out_data", bus.out_data, hold.data);
            check("out_pc", bus.out_pc, hold.pc);
            check("out_error", bus.out_error, hold.err);
         end
         if (phase == 1) begin
            check("mem_we", bus.mem_we, p_store);
            check("mem_addr", bus.mem_addr, p_addr);
            check("mem_wstrb", bus.mem_wstrb, p_strb);
            if (p_store) check("mem_wdata", bus.mem_wdata, p_wdata);
         end

         // Advance the model by the events the coming rising edge will see.
         if (!rst) begin
            hold_v = 0;
            phase  = 0;
         end else begin
            acc = bus.in_valid && exp_rdy;
            if (hold_v && bus.out_ready) hold_v = 0;
            if (phase == 2 && bus.mem_rvalid) begin
               hold = p_res;
               if (!p_store) hold.data = load_val(bus.mem_rdata, p_addr, p_op);
               hold_v = 1;
               phase  = 0;
               n_done++;
            end else if (phase == 1 && bus.mem_gnt) begin
               phase = 2;
            end
            if (acc) begin
               n   = 1 << bus.in_memop[1:0];
               off = int'(bus.in_addr[2:0]);
               mem = bus.in_memrd || bus.in_memwr;
               mis = mem && ((bus.in_addr % n) != 0);
               if (!mem || bus.in_error || mis) begin
                  hold_v     = 1;
                  hold.regwr = bus.in_regwr && !bus.in_error && !mis;
                  hold.rd    = bus.in_rd;
                  hold.data  = bus.in_addr;
                  hold.pc    = bus.in_pc;
                  hold.err   = bus.in_error || mis;
               end else begin
                  phase       = 1;
                  p_store     = bus.in_memwr;
                  p_addr      = bus.in_addr;
                  p_op        = bus.in_memop;
                  p_wdata     = bus.in_wdata << (8 * off);
                  p_strb      = p_store ? 8'(((16'd1 << n) - 16'd1) << off) : 8'h00;
                  p_res.regwr = p_store ? 1'b0 : bus.in_regwr;
                  p_res.rd    = bus.in_rd;
                  p_res.data  = bus.in_addr;
                  p_res.pc    = bus.in_pc;
                  p_res.err   = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic peek();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.in_valid = 1'b0; bus.in_regwr = 1'b0; bus.in_memrd = 1'b0; bus.in_memwr = 1'b0;
      bus.in_memop = 3'b000; bus.in_rd = '0; bus.in_addr = '0; bus.in_wdata = '0;
      bus.in_pc = '0; bus.in_error = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
   endtask

   task automatic entry(input logic rd_f, input logic wr_f, input logic [2:0] op,
                        input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd);
      bus.in_valid = 1'b1; bus.in_regwr = 1'b1; bus.in_memrd = rd_f; bus.in_memwr = wr_f;
      bus.in_memop = op; bus.in_addr = addr; bus.in_wdata = wdata; bus.in_rd = rd;
      bus.in_pc = addr + 64'h4000_0004; bus.in_error = 1'b0;
   endtask

   task automatic do_lb(input logic [2:0] op, input logic [63:0] expv);
      entry(1'b1, 1'b0, op, 64'h1003, 64'h0, 5'd7);
      peek(); step();
      idle_inputs(); bus.mem_gnt = 1'b1;
      peek();
      check("lb_mem_req", bus.mem_req, 1'b1);
      check("lb_mem_addr", bus.mem_addr, 64'h1003);
      check("lb_mem_wstrb", bus.mem_wstrb, 8'h00);
      step();
      bus.mem_gnt = 1'b0;
      peek(); check("lb_wait_no_req", bus.mem_req, 1'b0); step();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h0000_0000_8000_0000;
      peek(); check("lb_not_yet_valid", bus.out_valid, 1'b0); step();
      bus.mem_rvalid = 1'b0; bus.mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
      peek();
      check("lb_out_valid", bus.out_valid, 1'b1);
      check("lb_out_data", bus.out_data, expv);
      check("lb_out_rd", bus.out_rd, 5'd7);
      step();
   endtask

   task automatic rand_entry();
      int k = $urandom_range(0, 7);
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.in_regwr  = $urandom_range(0, 1) == 1;
      bus.in_rd     = 5'($urandom);
      bus.in_addr   = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) bus.in_addr[2:0] = 3'b000;
      bus.in_wdata  = {$urandom, $urandom};
      bus.in_pc     = {$urandom, $urandom};
      bus.in_error  = (k == 7);
      bus.in_memrd  = (k >= 2 && k <= 4) || (k == 7 && $urandom_range(0, 1) == 1);
      bus.in_memwr  = (k == 5 || k == 6);
      bus.in_memop  = bus.in_memwr ? 3'($urandom) : 3'($urandom_range(0, 6));
   endtask

   initial begin : driver
      rst = 1'b0;
      idle_inputs();
      bus.out_ready = 1'b1;
      bus.mem_rdata = '0;
      repeat (2) step();
      peek();
      check("rst_in_ready", bus.in_ready, 1'b0);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_mem_req", bus.mem_req, 1'b0);
      check("rst_out_data", bus.out_data, 64'h0);
      check("rst_mem_addr", bus.mem_addr, 64'h0);
      step();
      rst = 1'b1;

      // ALU passthrough
      entry(1'b0, 1'b0, 3'b000, 64'h1234, 64'h0, 5'd5);
      peek(); check("alu_in_ready", bus.in_ready, 1'b1); step();
      idle_inputs();
      peek();
      check("alu_out_valid", bus.out_valid, 1'b1);
      check("alu_out_data", bus.out_data, 64'h1234);
      check("alu_out_rd", bus.out_rd, 5'd5);
      check("alu_no_mem_req", bus.mem_req, 1'b0);
      step();
      peek(); check("alu_drained", bus.out_valid, 1'b0); step();

      do_lb(3'b000, 64'hFFFF_FFFF_FFFF_FF80);
      do_lb(3'b100, 64'h0000_0000_0000_0080);

      // Halfword store into the top lane
      entry(1'b0, 1'b1, 3'b001, 64'h1006, 64'hABCD, 5'd3);
      peek(); step();
      idle_inputs(); bus.mem_gnt = 1'b1;
      peek();
      check("sh_mem_we", bus.mem_we, 1'b1);
      check("sh_mem_wdata", bus.mem_wdata, 64'hABCD_0000_0000_0000);
      check("sh_mem_wstrb", bus.mem_wstrb, 8'hC0);
      step();
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1;
      peek(); step();
      bus.mem_rvalid = 1'b0;
      peek();
      check("sh_out_valid", bus.out_valid, 1'b1);
      check("sh_out_regwr", bus.out_regwr, 1'b0);
      check("sh_out_data", bus.out_data, 64'h1006);
      step();

      // Misaligned word load
      entry(1'b1, 1'b0, 3'b010, 64'h1002, 64'h0, 5'd9);
      peek(); step();
      idle_inputs();
      peek();
      check("mis_mem_req", bus.mem_req, 1'b0);
      check("mis_out_valid", bus.out_valid, 1'b1);
      check("mis_out_error", bus.out_error, 1'b1);
      check("mis_out_regwr", bus.out_regwr, 1'b0);
      step();

      // Grant and writeback backpressure, then back-to-back ALU entry
      entry(1'b1, 1'b0, 3'b011, 64'h2000, 64'h0, 5'd10);
      peek(); step();
      idle_inputs(); bus.out_ready = 1'b0;
      repeat (4) begin
         peek();
         check("stall_mem_req", bus.mem_req, 1'b1);
         check("stall_mem_addr", bus.mem_addr, 64'h2000);
         check("stall_in_ready", bus.in_ready, 1'b0);
         step();
      end
      bus.mem_gnt = 1'b1;
      peek(); step();
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h1122_3344_5566_7788;
      peek(); step();
      bus.mem_rvalid = 1'b0; bus.mem_rdata = 64'h0;
      repeat (3) begin
         peek();
         check("hold_out_valid", bus.out_valid, 1'b1);
         check("hold_out_data", bus.out_data, 64'h1122_3344_5566_7788);
         check("hold_in_ready", bus.in_ready, 1'b0);
         step();
      end
      bus.out_ready = 1'b1;
      entry(1'b0, 1'b0, 3'b000, 64'h55, 64'h0, 5'd2);
      peek(); check("b2b_in_ready", bus.in_ready, 1'b1); step();
      idle_inputs();
      peek();
      check("b2b_out_valid", bus.out_valid, 1'b1);
      check("b2b_out_data", bus.out_data, 64'h55);
      step();

      // Reset in WAIT abandons the load; a late response is ignored
      entry(1'b1, 1'b0, 3'b000, 64'h3000, 64'h0, 5'd4);
      peek(); step();
      idle_inputs(); bus.mem_gnt = 1'b1;
      peek(); step();
      bus.mem_gnt = 1'b0; rst = 1'b0;
      peek(); step();
      rst = 1'b1;
      peek();
      check("rstw_out_valid", bus.out_valid, 1'b0);
      check("rstw_in_ready", bus.in_ready, 1'b1);
      step();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hFF;
      peek(); step();
      bus.mem_rvalid = 1'b0;
      peek();
      check("stray_out_valid", bus.out_valid, 1'b0);
      check("stray_mem_req", bus.mem_req, 1'b0);
      step();
      entry(1'b0, 1'b0, 3'b000, 64'h77, 64'h0, 5'd1);
      peek(); step();
      idle_inputs();
      peek();
      check("post_rst_out_valid", bus.out_valid, 1'b1);
      check("post_rst_out_data", bus.out_data, 64'h77);
      step();

      // Randomized traffic
      n_done = 0;
      for (int c = 0; c < 4000; c++) begin
         rst            = ($urandom_range(0, 299) != 0);
         bus.out_ready  = ($urandom_range(0, 9) < 7);
         bus.mem_gnt    = ($urandom_range(0, 9) < 4);
         bus.mem_rvalid = ($urandom_range(0, 9) < 4);
         bus.mem_rdata  = {$urandom, $urandom};
         rand_entry();
         step();
      end
      rst = 1'b1;
      idle_inputs();
      repeat (3) step();
      check("random_mem_completions", n_done > 50, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
